// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel output path.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        BLACK    = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    localparam logic [3:0] FADE_MAX_LEVEL = 4'd8;

    // RGB332 -> RGB888 by bit replication, packed as {R8, G8, B8}.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] rgb);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = rgb[7:5];
        g = rgb[4:2];
        b = rgb[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

endpackage

// File: rtl/fade_level_ctrl.sv
// Frame-synchronous brightness fade controller: state, frame counter and level.
module fade_level_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned MAX_LEVEL       = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       fade_out_req,
    input  logic       fade_in_req,
    output logic [3:0] level,
    output logic       fade_busy,
    output logic       black_done
);

    localparam logic [3:0] LevelMax = 4'(MAX_LEVEL);
    localparam logic [3:0] CntLast  = 4'(FRAMES_PER_STEP - 1);

    fade_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  level_q, level_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fade_out_req) begin
                    state_d = FADE_OUT;
                    cnt_d   = '0;
                end
            end
            FADE_OUT: begin
                if (fade_out_req) begin
                    cnt_d = '0;
                end else if (fade_in_req) begin
                    state_d = FADE_IN;
                    cnt_d   = '0;
                end else if (startOfFrame) begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        // Saturating so a reversal caught at level 0 still lands in BLACK.
                        if (level_q <= 4'd1) begin
                            level_d = '0;
                            state_d = BLACK;
                            done_d  = 1'b1;
                        end else begin
                            level_d = level_q - 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            BLACK: begin
                if (fade_in_req) begin
                    state_d = FADE_IN;
                    cnt_d   = '0;
                end
            end
            FADE_IN: begin
                if (fade_out_req) begin
                    state_d = FADE_OUT;
                    cnt_d   = '0;
                end else if (fade_in_req) begin
                    cnt_d = '0;
                end else if (startOfFrame) begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        if (level_q >= LevelMax - 4'd1) begin
                            level_d = LevelMax;
                            state_d = IDLE;
                        end else begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FADE_OUT) || (state_d == FADE_IN);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= LevelMax;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign level      = level_q;
    assign fade_busy  = busy_q;
    assign black_done = done_q;

endmodule

// File: rtl/vga_fade_out_stage.sv
// VGA output stage: RGB332 expansion, brightness scaling and 1-cycle sync/blank alignment.
module vga_fade_out_stage
    import vga_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned MAX_LEVEL       = int'(FADE_MAX_LEVEL)
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] RGBIn,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_in,
    input  logic       startOfFrame,
    input  logic       fade_out_req,
    input  logic       fade_in_req,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       blank_out,
    output logic [3:0] level,
    output logic       fade_busy,
    output logic       black_done
);

    // Level 8 is unity gain, so the >>3 of the product is exact at full brightness.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [3:0] lvl);
        logic [11:0] p;
        p = {4'b0000, c} * {8'b0000_0000, lvl};
        return 8'(p >> 3);
    endfunction

    logic [23:0] rgb888;
    logic [23:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q, blank_q;

    fade_level_ctrl #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP),
        .MAX_LEVEL      (MAX_LEVEL)
    ) u_fade_level_ctrl (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .fade_out_req(fade_out_req),
        .fade_in_req (fade_in_req),
        .level       (level),
        .fade_busy   (fade_busy),
        .black_done  (black_done)
    );

    always_comb begin
        rgb888 = rgb332_expand(RGBIn);
        rgb_d  = '0;
        if (!blank_in) begin
            rgb_d = {scale_chan(rgb888[23:16], level),
                     scale_chan(rgb888[15:8],  level),
                     scale_chan(rgb888[7:0],   level)};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
            blank_q <= blank_in;
        end
    end

    assign red       = rgb_q[23:16];
    assign green     = rgb_q[15:8];
    assign blue      = rgb_q[7:0];
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign blank_out = blank_q;

endmodule

// File: tb/tb_vga_fade_out_stage.sv
// Directed self-checking bench for vga_fade_out_stage with FRAMES_PER_STEP = 2.
module tb_vga_fade_out_stage;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] RGBIn;
    logic       hsync_in, vsync_in, blank_in;
    logic       startOfFrame, fade_out_req, fade_in_req;
    logic [7:0] red, green, blue;
    logic       hsync_out, vsync_out, blank_out;
    logic [3:0] level;
    logic       fade_busy, black_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_fade_out_stage #(
        .FRAMES_PER_STEP(2)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .RGBIn       (RGBIn),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_in    (blank_in),
        .startOfFrame(startOfFrame),
        .fade_out_req(fade_out_req),
        .fade_in_req (fade_in_req),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_out   (blank_out),
        .level       (level),
        .fade_busy   (fade_busy),
        .black_done  (black_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; RGBIn = 8'h00; hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
        startOfFrame = 1'b0; fade_out_req = 1'b0; fade_in_req = 1'b0;
        #12;
        n_cmp++;
        if ({red, green, blue} !== 24'h0) begin
            n_err++; $display("FAIL reset_rgb: got %h want 000000", {red, green, blue});
        end
        n_cmp++;
        if ({hsync_out, vsync_out, blank_out} !== 3'b111) begin
            n_err++; $display("FAIL reset_sync: got %b want 111", {hsync_out, vsync_out, blank_out});
        end
        n_cmp++;
        if ({level, fade_busy, black_done} !== {4'd8, 2'b00}) begin
            n_err++; $display("FAIL reset_ctrl: level=%0d busy=%b done=%b want 8 0 0",
                              level, fade_busy, black_done);
        end
        resetN = 1'b1;
    endtask

    task automatic test_white();
        RGBIn = 8'hFF; blank_in = 1'b0;
        tick();
        n_cmp++;
        if ({red, green, blue, level} !== {24'hFFFFFF, 4'd8}) begin
            n_err++; $display("FAIL white: got rgb=%h level=%0d want FFFFFF 8",
                              {red, green, blue}, level);
        end
    endtask

    task automatic test_expand();
        RGBIn = 8'b101_010_01;
        tick();
        n_cmp++;
        if ({red, green, blue} !== 24'hB64955) begin
            n_err++; $display("FAIL expand_l8: got %h want B64955", {red, green, blue});
        end
    endtask

    task automatic test_fade_out();
        int done_cnt = 0;
        fade_out_req = 1'b1;
        tick();
        fade_out_req = 1'b0;
        n_cmp++;
        if ({fade_busy, level} !== {1'b1, 4'd8}) begin
            n_err++; $display("FAIL fo_start: busy=%b level=%0d want 1 8", fade_busy, level);
        end
        for (int k = 1; k <= 16; k++) begin
            sof_pulse();
            if (black_done) done_cnt++;
            n_cmp++;
            if (level !== 4'(8 - k / 2) || fade_busy !== (k < 16) || black_done !== (k == 16)) begin
                n_err++;
                $display("FAIL fo_step%0d: level=%0d busy=%b done=%b want %0d %b %b",
                         k, level, fade_busy, black_done, 8 - k / 2, k < 16, k == 16);
            end
            tick();
            if (black_done) done_cnt++;
            if (k == 8) begin
                n_cmp++;
                if ({red, green, blue} !== 24'h5B242A) begin
                    n_err++; $display("FAIL expand_l4: got %h want 5B242A", {red, green, blue});
                end
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++; $display("FAIL fo_done_count: got %0d want 1", done_cnt);
        end
        RGBIn = 8'hFF;
        tick();
        n_cmp++;
        if ({red, green, blue} !== 24'h0) begin
            n_err++; $display("FAIL black_ff: got %h want 000000", {red, green, blue});
        end
        RGBIn = 8'h5A;
        tick();
        n_cmp++;
        if ({red, green, blue} !== 24'h0) begin
            n_err++; $display("FAIL black_5a: got %h want 000000", {red, green, blue});
        end
    endtask

    task automatic test_fade_in();
        RGBIn = 8'hFF;
        fade_in_req = 1'b1;
        tick();
        fade_in_req = 1'b0;
        n_cmp++;
        if ({fade_busy, level} !== {1'b1, 4'd0}) begin
            n_err++; $display("FAIL fi_start: busy=%b level=%0d want 1 0", fade_busy, level);
        end
        for (int k = 1; k <= 16; k++) begin
            sof_pulse();
            tick();
        end
        n_cmp++;
        if ({fade_busy, level} !== {1'b0, 4'd8}) begin
            n_err++; $display("FAIL fi_end: busy=%b level=%0d want 0 8", fade_busy, level);
        end
        n_cmp++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
            n_err++; $display("FAIL fi_rgb: got %h want FFFFFF", {red, green, blue});
        end
        fade_in_req = 1'b1;
        tick();
        fade_in_req = 1'b0;
        sof_pulse();
        sof_pulse();
        n_cmp++;
        if ({fade_busy, level} !== {1'b0, 4'd8}) begin
            n_err++; $display("FAIL idle_fi_ignored: busy=%b level=%0d want 0 8", fade_busy, level);
        end
    endtask

    task automatic test_both_req();
        fade_out_req = 1'b1;
        tick();
        fade_out_req = 1'b0;
        for (int k = 1; k <= 7; k++) sof_pulse();
        n_cmp++;
        if (level !== 4'd5) begin
            n_err++; $display("FAIL both_pre: level=%0d want 5", level);
        end
        // Counter is mid-step here; the simultaneous requests must clear it.
        fade_out_req = 1'b1; fade_in_req = 1'b1;
        tick();
        fade_out_req = 1'b0; fade_in_req = 1'b0;
        n_cmp++;
        if ({fade_busy, level} !== {1'b1, 4'd5}) begin
            n_err++; $display("FAIL both_req: busy=%b level=%0d want 1 5", fade_busy, level);
        end
        sof_pulse();
        n_cmp++;
        if (level !== 4'd5) begin
            n_err++; $display("FAIL both_cnt_clr: level=%0d want 5", level);
        end
        sof_pulse();
        n_cmp++;
        if ({fade_busy, level} !== {1'b1, 4'd4}) begin
            n_err++; $display("FAIL both_step: busy=%b level=%0d want 1 4", fade_busy, level);
        end
    endtask

    task automatic test_blank_sync();
        blank_in = 1'b1; RGBIn = 8'hFF;
        tick();
        n_cmp++;
        if ({red, green, blue, blank_out} !== {24'h0, 1'b1}) begin
            n_err++; $display("FAIL blank: rgb=%h blank_out=%b want 000000 1",
                              {red, green, blue}, blank_out);
        end
        hsync_in = 1'b0; vsync_in = 1'b0;
        #2;
        n_cmp++;
        if ({hsync_out, vsync_out} !== 2'b11) begin
            n_err++; $display("FAIL sync_early: got %b want 11", {hsync_out, vsync_out});
        end
        tick();
        n_cmp++;
        if ({hsync_out, vsync_out} !== 2'b00) begin
            n_err++; $display("FAIL sync_delay: got %b want 00", {hsync_out, vsync_out});
        end
        hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;
        tick();
        n_cmp++;
        if ({hsync_out, vsync_out, blank_out} !== 3'b110) begin
            n_err++; $display("FAIL sync_back: got %b want 110", {hsync_out, vsync_out, blank_out});
        end
    endtask

    task automatic test_reset_mid();
        sof_pulse();
        sof_pulse();
        n_cmp++;
        if (level !== 4'd3) begin
            n_err++; $display("FAIL mid_pre: level=%0d want 3", level);
        end
        RGBIn = 8'hFF;
        tick();
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++;
        if ({level, fade_busy, red, hsync_out, blank_out} !== {4'd8, 1'b0, 8'h00, 2'b11}) begin
            n_err++; $display("FAIL async_reset: level=%0d busy=%b red=%h hs=%b blank=%b want 8 0 00 1 1",
                              level, fade_busy, red, hsync_out, blank_out);
        end
        #3;
        resetN = 1'b1;
        tick();
        n_cmp++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
            n_err++; $display("FAIL post_reset_rgb: got %h want FFFFFF", {red, green, blue});
        end
    endtask

    initial begin
        test_reset();
        test_white();
        test_expand();
        test_fade_out();
        test_fade_in();
        test_both_req();
        test_blank_sync();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
